// File: rtl/dom_tree_builder_pkg.sv
// Shared widths, error codes and FSM encoding for the DOM tree builder.
// The tag/attribute width macros are the ones the element parser already uses.
`ifndef ELE_TAG_BITES
`define ELE_TAG_BITES 8
`endif
`ifndef ATTRIBUTE_TYPE_BITES
`define ATTRIBUTE_TYPE_BITES 8
`endif
`ifndef ATTRIBUTE_VAL_BITES
`define ATTRIBUTE_VAL_BITES 16
`endif
`ifndef NO_PARENT_ID
`define NO_PARENT_ID(bits) {(bits){1'b1}}
`endif

package dom_tree_builder_pkg;

    localparam int TAG_W   = `ELE_TAG_BITES;
    localparam int ATYPE_W = `ATTRIBUTE_TYPE_BITES;
    localparam int AVAL_W  = `ATTRIBUTE_VAL_BITES;

    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_TRAILING      = 3'd1,
        ERR_UNDERFLOW     = 3'd2,
        ERR_OVERFLOW      = 3'd3,
        ERR_ID_EXHAUSTED  = 3'd4,
        ERR_MISMATCH      = 3'd5,
        ERR_ATTR_ON_CLOSE = 3'd6
    } err_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IN_DOC = 2'd1,
        ST_DONE   = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

endpackage

// File: rtl/dom_tree_builder_tag_stack.sv
// LIFO of {tag, node id} tracking the currently open elements.
// Push into a full stack or pop from an empty one is ignored; the caller traps both.
module dom_tree_builder_tag_stack #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 8,
    parameter int ID_W  = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [TAG_W-1:0]             i_push_tag,
    input  logic [ID_W-1:0]              i_push_id,
    output logic [TAG_W-1:0]             o_top_tag,
    output logic [ID_W-1:0]              o_top_id,
    output logic [$clog2(DEPTH+1)-1:0]   o_depth,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [TAG_W-1:0] r_tag [DEPTH];
    logic [ID_W-1:0]  r_id  [DEPTH];
    logic [CNT_W-1:0] r_depth;
    logic [IDX_W-1:0] w_push_idx;
    logic [IDX_W-1:0] w_top_idx;

    assign o_full     = (r_depth == CNT_W'(DEPTH));
    assign o_empty    = (r_depth == '0);
    assign w_push_idx = IDX_W'(r_depth);
    assign w_top_idx  = IDX_W'(r_depth - CNT_W'(1));
    assign o_top_tag  = r_tag[w_top_idx];
    assign o_top_id   = r_id[w_top_idx];
    assign o_depth    = r_depth;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_depth <= '0;
        end else if (i_push && !o_full) begin
            r_depth <= r_depth + CNT_W'(1);
        end else if (i_pop && !o_empty) begin
            r_depth <= r_depth - CNT_W'(1);
        end
    end

    // Storage needs no reset: entries are only read below the depth pointer.
    always_ff @(posedge clock) begin
        if (!reset && i_push && !o_full) begin
            r_tag[w_push_idx] <= i_push_tag;
            r_id[w_push_idx]  <= i_push_id;
        end
    end

endmodule

// File: rtl/dom_tree_builder.sv
// Builds tree node records (id, parent, tag, depth) from a flat open/close tag stream,
// forwards attributes tagged with their owning node, and latches the first error seen.
module dom_tree_builder
    import dom_tree_builder_pkg::*;
#(
    parameter int MAX_DEPTH    = 16,
    parameter int NODE_ID_BITS = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             tag_valid,
    input  logic [TAG_W-1:0]                 element_tag,
    input  logic                             is_closing_tag,
    input  logic                             attr_valid,
    input  logic [ATYPE_W-1:0]               attribute_type,
    input  logic [AVAL_W-1:0]                attribute_value,
    output logic                             node_valid,
    output logic                             close_valid,
    output logic [NODE_ID_BITS-1:0]          node_id,
    output logic [NODE_ID_BITS-1:0]          parent_id,
    output logic [TAG_W-1:0]                 node_tag,
    output logic [$clog2(MAX_DEPTH+1)-1:0]   depth,
    output logic                             attr_out_valid,
    output logic [NODE_ID_BITS-1:0]          attr_node_id,
    output logic [ATYPE_W-1:0]               attr_type,
    output logic [AVAL_W-1:0]                attr_value,
    output logic                             doc_done,
    output logic                             error,
    output logic [2:0]                       error_code,
    output state_t                           dbg_state
);

    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam logic [NODE_ID_BITS-1:0] NO_PARENT = `NO_PARENT_ID(NODE_ID_BITS);

    state_t                    r_state, w_state_next;
    logic [NODE_ID_BITS-1:0]   r_next_id;
    logic                      r_attr_seen;
    logic                      r_node_valid, r_close_valid, r_attr_out_valid, r_doc_done;
    logic [NODE_ID_BITS-1:0]   r_node_id, r_parent_id, r_attr_node_id;
    logic [TAG_W-1:0]          r_node_tag;
    logic [DEPTH_W-1:0]        r_depth;
    logic [ATYPE_W-1:0]        r_attr_type;
    logic [AVAL_W-1:0]         r_attr_value;
    logic                      r_error;
    err_t                      r_error_code;

    logic                      w_tag_take, w_attr_take;
    logic                      w_push, w_pop;
    logic                      w_node_fire, w_close_fire, w_done_fire;
    logic                      w_err;
    err_t                      w_err_code;
    logic [TAG_W-1:0]          w_top_tag;
    logic [NODE_ID_BITS-1:0]   w_top_id;
    logic [DEPTH_W-1:0]        w_stk_depth;
    logic                      w_full, w_empty;

    dom_tree_builder_tag_stack #(
        .DEPTH (MAX_DEPTH),
        .TAG_W (TAG_W),
        .ID_W  (NODE_ID_BITS)
    ) tag_stack (
        .clock      (clock),
        .reset      (reset),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_push_tag (element_tag),
        .i_push_id  (r_next_id),
        .o_top_tag  (w_top_tag),
        .o_top_id   (w_top_id),
        .o_depth    (w_stk_depth),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Inputs are single-cycle pulses with no back-pressure; an attribute arriving with a
    // tag is handled first, so it belongs to the pending node and counts toward attr_seen.
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_node_fire  = 1'b0;
        w_close_fire = 1'b0;
        w_done_fire  = 1'b0;
        w_err        = 1'b0;
        w_err_code   = ERR_NONE;
        w_attr_take  = attr_valid && (r_state == ST_IDLE || r_state == ST_IN_DOC);
        w_tag_take   = tag_valid && (r_state != ST_FAULT);

        if (w_tag_take) begin
            if (r_state == ST_DONE) begin
                w_err      = 1'b1;
                w_err_code = ERR_TRAILING;
            end else if (is_closing_tag) begin
                if (w_empty) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_UNDERFLOW;
                end else begin
                    w_pop        = 1'b1;
                    w_close_fire = 1'b1;
                    if (w_stk_depth == DEPTH_W'(1)) begin
                        w_done_fire  = 1'b1;
                        w_state_next = ST_DONE;
                    end
                    if (element_tag != w_top_tag) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_MISMATCH;
                    end else if (r_attr_seen || w_attr_take) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_ATTR_ON_CLOSE;
                    end
                end
            end else begin
                if (w_full) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_OVERFLOW;
                end else if (r_next_id == NO_PARENT) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_ID_EXHAUSTED;
                end else begin
                    w_push       = 1'b1;
                    w_node_fire  = 1'b1;
                    w_state_next = ST_IN_DOC;
                end
            end
            if (w_err) begin
                w_state_next = ST_FAULT;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_next_id        <= '0;
            r_attr_seen      <= 1'b0;
            r_node_valid     <= 1'b0;
            r_close_valid    <= 1'b0;
            r_attr_out_valid <= 1'b0;
            r_doc_done       <= 1'b0;
            r_node_id        <= '0;
            r_parent_id      <= '0;
            r_node_tag       <= '0;
            r_depth          <= '0;
            r_attr_node_id   <= '0;
            r_attr_type      <= '0;
            r_attr_value     <= '0;
            r_error          <= 1'b0;
            r_error_code     <= ERR_NONE;
        end else begin
            r_state          <= w_state_next;
            r_node_valid     <= w_node_fire;
            r_close_valid    <= w_close_fire;
            r_doc_done       <= w_done_fire;
            r_attr_out_valid <= w_attr_take;

            if (w_attr_take) begin
                r_attr_node_id <= r_next_id;
                r_attr_type    <= attribute_type;
                r_attr_value   <= attribute_value;
            end

            if (w_tag_take) begin
                r_attr_seen <= 1'b0;
            end else if (w_attr_take) begin
                r_attr_seen <= 1'b1;
            end

            if (w_node_fire) begin
                r_node_id   <= r_next_id;
                r_parent_id <= w_empty ? NO_PARENT : w_top_id;
                r_node_tag  <= element_tag;
                r_depth     <= w_stk_depth + DEPTH_W'(1);
                r_next_id   <= r_next_id + NODE_ID_BITS'(1);
            end else if (w_close_fire) begin
                r_node_id   <= w_top_id;
                r_node_tag  <= w_top_tag;
                r_depth     <= w_stk_depth - DEPTH_W'(1);
            end

            if (w_err) begin
                r_error      <= 1'b1;
                r_error_code <= w_err_code;
            end
        end
    end

    assign node_valid     = r_node_valid;
    assign close_valid    = r_close_valid;
    assign node_id        = r_node_id;
    assign parent_id      = r_parent_id;
    assign node_tag       = r_node_tag;
    assign depth          = r_depth;
    assign attr_out_valid = r_attr_out_valid;
    assign attr_node_id   = r_attr_node_id;
    assign attr_type      = r_attr_type;
    assign attr_value     = r_attr_value;
    assign doc_done       = r_doc_done;
    assign error          = r_error;
    assign error_code     = r_error_code;
    assign dbg_state      = r_state;

endmodule

// File: doc/dom_tree_builder.md
# dom_tree_builder

Downstream consumer of the element tag parser. It turns the flat stream of parsed open/close tags and attribute key/value records into tree-structured node records: node id, parent id, tag, depth and per-node attributes. It tracks nesting on an internal LIFO and flags malformed documents with a sticky error code. Its output feeds the layout/render stages.

## Interface
Parameters:
- MAX_DEPTH, 16: maximum nesting depth (stack entries).
- NODE_ID_BITS, 8: node id width. The all-ones id is reserved as NO_PARENT.

Ports:
- clock  in  1  global clock, all logic on posedge
- reset  in  1  synchronous, active-high; clears all state at the next posedge
- tag_valid  in  1  one-cycle pulse: the element parser has finished a tag
- element_tag  in  `ELE_TAG_BITES  tag id, sampled with tag_valid
- is_closing_tag  in  1  1 = closing tag, sampled with tag_valid
- attr_valid  in  1  one-cycle pulse: one attribute record is present
- attribute_type  in  `ATTRIBUTE_TYPE_BITES  attribute key
- attribute_value  in  `ATTRIBUTE_VAL_BITES  attribute value
- node_valid  out  1  pulse: a node was opened
- close_valid  out  1  pulse: a node was closed
- node_id  out  NODE_ID_BITS  id of the opened or closed node
- parent_id  out  NODE_ID_BITS  parent of the opened node; NO_PARENT for the root
- node_tag  out  `ELE_TAG_BITES  tag of the opened or closed node
- depth  out  $clog2(MAX_DEPTH+1)  stack depth after the operation
- attr_out_valid  out  1  pulse: attribute record forwarded
- attr_node_id  out  NODE_ID_BITS  id of the node that owns the attribute
- attr_type / attr_value  out  as inputs  forwarded attribute
- doc_done  out  1  pulse when the root element closes
- error  out  1  sticky error flag
- error_code  out  3  first error seen; ERR_NONE while error = 0

## Operation
- FSM states:
  - IDLE: no root yet.
  - IN_DOC: stack non-empty.
  - DONE: root has closed.
  - FAULT: error raised.
- next_id counter starts at 0. Each accepted open assigns node_id = next_id, then increments.
- Attributes always belong to the pending tag. attr_node_id = next_id. attr_seen is set and cleared on each tag_valid.
- Open tag (IDLE or IN_DOC):
  - push {tag, id}.
  - parent_id = top id before the push, or NO_PARENT if the stack is empty.
  - Go to IN_DOC.
- Close tag:
  - Pop the stack.
  - Output the popped id and tag.
  - If depth becomes 0, pulse doc_done and go to DONE.
- Error rules, evaluated in priority order on tag_valid:
  1. ERR_TRAILING (1): any tag_valid in DONE.
  2. ERR_UNDERFLOW (2): close with the stack empty.
  3. ERR_OVERFLOW (3): open with depth == MAX_DEPTH. No push, no node_valid.
  4. ERR_ID_EXHAUSTED (4): open with next_id == NO_PARENT. No push.
  5. ERR_MISMATCH (5): close whose tag differs from the top-of-stack tag. The pop still happens and close_valid still pulses.
  6. ERR_ATTR_ON_CLOSE (6): close with attr_seen = 1. The close is processed normally.
- Any error sets error = 1, latches error_code, and moves to FAULT.
- In FAULT, all inputs are ignored and no pulses are produced, until reset.
- attr_valid in DONE or FAULT is dropped. In DONE it does not raise an error.

## Timing
- All outputs are registered. Latency is 1 cycle from an input pulse to its output pulse.
- Each pulse output is high for exactly one cycle. Data outputs hold their value until the next pulse.
- Reset values: all pulses 0, node_id/parent_id/attr_node_id = 0, node_tag = 0, depth = 0, attr fields = 0, error = 0, error_code = ERR_NONE, FSM = IDLE, next_id = 0, attr_seen = 0.
- tag_valid and attr_valid in the same cycle: the attribute is processed first.
  - attr_out_valid goes out with attr_node_id = next_id as it was before the tag.
  - The tag is then handled in the same cycle.
  - For a close tag, attr_seen counts as 1.
- Back-to-back tag_valid pulses on consecutive cycles are supported, at one tag per cycle with no stall.
- Reset asserted mid-document: the state is fully cleared on that edge, and inputs sampled while reset = 1 are ignored.
- depth never wraps. Overflow and underflow are trapped by errors 3 and 2.

## Structure
- Shared defines header holds:
  - ERR_* codes.
  - NO_PARENT derivation.
  - Existing `ELE_TAG_BITES, `ATTRIBUTE_TYPE_BITES and `ATTRIBUTE_VAL_BITES.
- Sub-module tag_stack: a parameterised LIFO of {tag, id} with the following interface:
  - push, pop, top, depth, full, empty.
  - Same-cycle push and pop are not used here.
- The FSM, id counter and error logic live in dom_tree_builder.

## Test plan
- Open d, open p, close p, close d: node (0, NO_PARENT, tag 0, depth 1) and node (1, parent 0, tag 1, depth 2). Closes report id 1 at depth 1, then id 0 at depth 0, with doc_done on the final close.
- Attr (type 2, value 5) then open a: attr_out_valid with attr_node_id 0 one cycle later, then node_valid with id 0.
- Open d, close p: close_valid with id 0, error = 1, error_code = 5, FSM in FAULT. A subsequent open produces no node_valid.
- MAX_DEPTH = 2: open, open, open gives 2 node_valid pulses, then error_code 3 with depth still 2.
- Close as the first tag gives error_code 2. Open, close, then open gives doc_done followed by error_code 1.
- Reset asserted at depth 3: the next open gets id 0, parent NO_PARENT, depth 1, and error = 0.
